// File: rtl/segre_pkg.sv
// Shared icache geometry constants and the refill FSM state encoding.
package segre_pkg;

    localparam int unsigned ICACHE_ADDR_SIZE  = 32;
    localparam int unsigned ICACHE_NUM_LANES  = 4;
    localparam int unsigned ICACHE_INDEX_SIZE = 2;
    localparam int unsigned ICACHE_BYTE_SIZE  = 4;
    localparam int unsigned ICACHE_TAG_SIZE   = ICACHE_ADDR_SIZE - ICACHE_BYTE_SIZE;
    localparam int unsigned ICACHE_LINE_BEATS = 4;

    typedef enum logic [1:0] {
        REFILL_IDLE      = 2'd0,
        REFILL_REQ       = 2'd1,
        REFILL_WAIT_DATA = 2'd2,
        REFILL_FILL      = 2'd3
    } refill_state_e;

endpackage

// File: rtl/segre_icache_victim.sv
// Victim lane picker: lowest invalid lane, else a round-robin pointer over full sets.
module segre_icache_victim
    import segre_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rsn_i,
    input  logic [ICACHE_NUM_LANES-1:0]  lane_valid_i,
    input  logic                         advance_i,
    output logic [ICACHE_INDEX_SIZE-1:0] victim_idx_c
);

    logic [ICACHE_INDEX_SIZE-1:0] rr_q, rr_d;
    logic                         found;

    always_comb begin
        victim_idx_c = rr_q;
        found        = 1'b0;
        for (int i = 0; i < int'(ICACHE_NUM_LANES); i++) begin
            if (!found && !lane_valid_i[i]) begin
                victim_idx_c = ICACHE_INDEX_SIZE'(i);
                found        = 1'b1;
            end
        end
    end

    // Pointer only moves when it was actually used to pick the victim.
    always_comb begin
        rr_d = rr_q;
        if (advance_i && (&lane_valid_i)) begin
            if (rr_q == ICACHE_INDEX_SIZE'(ICACHE_NUM_LANES - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = rr_q + ICACHE_INDEX_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/segre_icache_refill.sv
// Icache line refill engine: miss -> line read -> beat assembly -> one-cycle fill.
// Optional miss counter enabled by defining SEGRE_ICACHE_REFILL_PERF_EN.
module segre_icache_refill
    import segre_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned LINE_BEATS = ICACHE_LINE_BEATS
) (
    input  logic                             clk_i,
    input  logic                             rsn_i,
    input  logic                             miss_i,
    input  logic [ADDR_WIDTH-1:0]            miss_addr_i,
    input  logic [ICACHE_NUM_LANES-1:0]      lane_valid_i,
    input  logic                             invalidate_i,
    output logic                             busy_o,
    output logic                             mem_req_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    input  logic                             mem_gnt_i,
    input  logic                             mem_rvalid_i,
    input  logic [WORD_WIDTH-1:0]            mem_rdata_i,
    output logic                             fill_valid_o,
    output logic [ICACHE_INDEX_SIZE-1:0]     fill_index_o,
    output logic [ICACHE_TAG_SIZE-1:0]       fill_tag_o,
    output logic [LINE_BEATS*WORD_WIDTH-1:0] fill_data_o,
    output logic [31:0]                      miss_count_o
);

    localparam int unsigned BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int unsigned LINE_W = LINE_BEATS * WORD_WIDTH;

    refill_state_e                state_q, state_d;
    logic [ICACHE_TAG_SIZE-1:0]   tag_q, tag_d;
    logic [ICACHE_INDEX_SIZE-1:0] idx_q, idx_d;
    logic [BEAT_W-1:0]            beat_q, beat_d;
    logic [LINE_W-1:0]            line_q, line_d;
    logic                         drop_q, drop_d;
    logic                         accept_miss;
    logic                         last_beat;
    logic [ICACHE_INDEX_SIZE-1:0] victim_idx;

    assign accept_miss = (state_q == REFILL_IDLE) && miss_i && !invalidate_i;
    assign last_beat   = (beat_q == BEAT_W'(LINE_BEATS - 1));

    segre_icache_victim u_victim (
        .clk_i        (clk_i),
        .rsn_i        (rsn_i),
        .lane_valid_i (lane_valid_i),
        .advance_i    (accept_miss),
        .victim_idx_c (victim_idx)
    );

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= REFILL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            REFILL_IDLE:      if (accept_miss) state_d = REFILL_REQ;
            REFILL_REQ:       if (mem_gnt_i) state_d = REFILL_WAIT_DATA;
            REFILL_WAIT_DATA: if (mem_rvalid_i && last_beat) state_d = REFILL_FILL;
            REFILL_FILL:      state_d = REFILL_IDLE;
            default:          state_d = REFILL_IDLE;
        endcase
    end

    // Transaction context: tag/victim latched at acceptance, beats packed LSB-first.
    always_comb begin
        tag_d  = tag_q;
        idx_d  = idx_q;
        beat_d = beat_q;
        line_d = line_q;
        drop_d = drop_q;
        if (accept_miss) begin
            tag_d  = ICACHE_TAG_SIZE'(miss_addr_i >> ICACHE_BYTE_SIZE);
            idx_d  = victim_idx;
            beat_d = '0;
            drop_d = 1'b0;
        end
        if ((state_q == REFILL_REQ || state_q == REFILL_WAIT_DATA) && invalidate_i) begin
            drop_d = 1'b1;
        end
        if (state_q == REFILL_WAIT_DATA && mem_rvalid_i) begin
            line_d[beat_q*WORD_WIDTH +: WORD_WIDTH] = mem_rdata_i;
            beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
        end
        if (state_q == REFILL_FILL) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            tag_q  <= '0;
            idx_q  <= '0;
            beat_q <= '0;
            line_q <= '0;
            drop_q <= 1'b0;
        end else begin
            tag_q  <= tag_d;
            idx_q  <= idx_d;
            beat_q <= beat_d;
            line_q <= line_d;
            drop_q <= drop_d;
        end
    end

    // Outputs decoded from state; a flush in the fill cycle must kill the write the same cycle.
    always_comb begin
        busy_o       = (state_q != REFILL_IDLE);
        mem_req_o    = (state_q == REFILL_REQ);
        mem_addr_o   = ADDR_WIDTH'({tag_q, {ICACHE_BYTE_SIZE{1'b0}}});
        fill_valid_o = (state_q == REFILL_FILL) && !drop_q && !invalidate_i;
        fill_index_o = idx_q;
        fill_tag_o   = tag_q;
        fill_data_o  = line_q;
    end

`ifdef SEGRE_ICACHE_REFILL_PERF_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept_miss && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign miss_count_o = cnt_q;
`else
    assign miss_count_o = '0;
`endif

endmodule

// File: doc/segre_icache_refill.md
SEGRE_ICACHE_REFILL -- requirements
Module: segre_icache_refill

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, memory data beat width.
REQ-003 SHALL have parameter LINE_BEATS, default 4, beats per cache line (line = LINE_BEATS*WORD_WIDTH bits).
REQ-004 SHALL have port clk_i, input, 1, sole clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rsn_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port miss_i, input, 1, icache tag lookup missed.
REQ-007 SHALL have port miss_addr_i, input, ADDR_WIDTH, fetch address of the miss.
REQ-008 SHALL have port lane_valid_i, input, ICACHE_NUM_LANES, current valid bit per lane.
REQ-009 SHALL have port invalidate_i, input, 1, cache flush request.
REQ-010 SHALL have port busy_o, output, 1, refill in progress; new misses ignored.
REQ-011 SHALL have ports mem_req_o (output, 1), mem_addr_o (output, ADDR_WIDTH), mem_gnt_i (input, 1): line-read request handshake.
REQ-012 SHALL have ports mem_rvalid_i (input, 1), mem_rdata_i (input, WORD_WIDTH): response beats.
REQ-013 SHALL have ports fill_valid_o (output, 1), fill_index_o (output, ICACHE_INDEX_SIZE), fill_tag_o (output, ICACHE_TAG_SIZE), fill_data_o (output, LINE_BEATS*WORD_WIDTH): tag/data array write.
REQ-014 SHALL have port miss_count_o, output, 32, refill counter (see Configuration).

Function
REQ-015 SHALL implement FSM IDLE -> REQ -> WAIT_DATA -> FILL -> IDLE.
REQ-016 IDLE: miss_i=1 SHALL latch tag = miss_addr_i[ADDR_WIDTH-1:ICACHE_BYTE_SIZE], select victim, go to REQ next cycle.
REQ-017 Victim SHALL be lowest-index lane with lane_valid_i=0; if all valid, round-robin pointer value, pointer then incremented modulo ICACHE_NUM_LANES.
REQ-018 REQ: mem_req_o=1, mem_addr_o={tag, ICACHE_BYTE_SIZE zeros}, both held stable until mem_req_o&mem_gnt_i, then go to WAIT_DATA.
REQ-019 WAIT_DATA: each mem_rvalid_i cycle SHALL store mem_rdata_i at beat k (beat 0 in LSBs), k counting 0..LINE_BEATS-1; after beat LINE_BEATS-1 go to FILL.
REQ-020 mem_rvalid_i outside WAIT_DATA SHALL be ignored.
REQ-021 FILL: fill_valid_o SHALL be high exactly one cycle with latched index, tag, assembled line; then IDLE.
REQ-022 busy_o SHALL be 1 in every state except IDLE; miss_i while busy SHALL be ignored.
REQ-023 invalidate_i in REQ/WAIT_DATA SHALL set a drop flag; transaction completes, but FILL asserts no fill_valid_o.
REQ-024 invalidate_i in FILL cycle SHALL suppress fill_valid_o that cycle.
REQ-025 fill_* data/index/tag outputs SHALL be don't-care when fill_valid_o=0.
REQ-026 miss_i in IDLE coincident with invalidate_i SHALL be ignored.

Reset
REQ-027 rsn_i=0 SHALL asynchronously force IDLE, beat count 0, round-robin pointer 0, drop flag 0, miss_count_o 0, all valid/req outputs 0.
REQ-028 Reset mid-refill SHALL abandon transaction; late beats after reset ignored per REQ-020.

Configuration
REQ-029 With SEGRE_ICACHE_REFILL_PERF_EN defined, miss_count_o SHALL increment on each accepted miss, saturating at 0xFFFF_FFFF.
REQ-030 Without SEGRE_ICACHE_REFILL_PERF_EN, miss_count_o SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-031 FSM state enum and ICACHE_LINE_BEATS constant SHALL live in segre_pkg alongside ICACHE_* sizes.
REQ-032 Victim selection SHALL be sub-module segre_icache_victim (lane_valid in, advance in, index out, pointer state).

Verification
REQ-033 Miss addr 0x0000_1234, all lanes invalid, gnt next cycle, beats 0xA0,0xA1,0xA2,0xA3 -> mem_addr_o 0x0000_1230; one fill pulse, index 0, tag 0x0000123, data 0x000000A3_000000A2_000000A1_000000A0.
REQ-034 lane_valid_i=4'b1011, miss -> fill_index_o 2; lane_valid_i=4'b1111 for three misses -> indices 0,1,2.
REQ-035 mem_gnt_i held 0 for 5 cycles -> mem_req_o and mem_addr_o stable 5 cycles, no beats accepted.
REQ-036 invalidate_i pulse during beat 2 -> all 4 beats consumed, no fill_valid_o, busy_o drops after FILL.
REQ-037 rsn_i low during WAIT_DATA, then extra rvalid beats -> outputs 0, FSM IDLE, no fill pulse.
REQ-038 PERF_EN defined, 3 misses plus 1 ignored busy miss -> miss_count_o 3; undefined -> 0.
